// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds parity modes, receiver states, oversample constants and tuser indices.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2,
    PAR_RSVD = 2'd3
  } parity_mode_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int OVS        = 16;
  localparam int SAMPLE_MID = 8;

  localparam int TUSER_FRM = 0;
  localparam int TUSER_PAR = 1;
  localparam int TUSER_BRK = 2;

  function automatic logic maj3(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with full/empty/level flags.
// Read data reads as zero while empty so idle outputs stay quiet.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;

  assign level_o = wr_ptr - rd_ptr;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (level_o == '0);
  assign pop     = rd_en_i && !empty_o;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts it.
  assign push    = wr_en_i && (!full_o || pop);

  assign rd_data_o = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver: 16x oversampling, 3-sample majority, parity/stop checks.
// Received words and error flags are queued in a FIFO on an AXI-Stream port.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_i,
  input  logic [15:0]                   baud_div_i,
  input  logic [1:0]                    parity_mode_i,
  input  logic                          stop_bits_i,
  output logic [DATA_BITS-1:0]          mst_axis_tdata_o,
  output logic [2:0]                    mst_axis_tuser_o,
  output logic                          mst_axis_tvalid_o,
  input  logic                          mst_axis_tready_i,
  output logic                          overrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          busy_o
);

  localparam int W = DATA_BITS + 3;

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic                 rx_prev;
  rx_state_t            state;
  logic [15:0]          tick_cnt;
  logic [15:0]          div_q;
  logic [15:0]          div_cur;
  parity_mode_t         pmode_q;
  logic                 two_q;
  logic [3:0]           s_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] data_q;
  logic                 s7, s8;
  logic                 seen_one;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 brk_q;
  logic                 push_q;
  logic [W-1:0]         push_word;
  logic                 ov_q;
  logic                 tick, start_det, maj, mid, last, par_en;
  logic [2:0]           tuser_now;
  logic [W-1:0]         rd_word;
  logic                 full, empty;

  assign rx_s      = sync_q[1];
  assign div_cur   = (state == RX_IDLE) ? baud_div_i : div_q;
  assign tick      = (tick_cnt >= div_cur);
  assign start_det = (state == RX_IDLE) && !rx_s && rx_prev;
  assign maj       = maj3(s7, s8, rx_s);
  assign mid       = tick && (s_cnt == 4'(SAMPLE_MID + 1));
  assign last      = tick && (s_cnt == 4'(OVS - 1));
  assign par_en    = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);

  always_comb begin
    tuser_now            = '0;
    tuser_now[TUSER_BRK] = (bit_cnt == 4'd0) ? !(seen_one | maj) : brk_q;
    tuser_now[TUSER_PAR] = perr_q;
    tuser_now[TUSER_FRM] = ferr_q | !maj;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      rx_prev <= sync_q[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RX_IDLE;
      tick_cnt  <= '0;
      div_q     <= '0;
      pmode_q   <= PAR_NONE;
      two_q     <= 1'b0;
      s_cnt     <= '0;
      bit_cnt   <= '0;
      data_q    <= '0;
      s7        <= 1'b1;
      s8        <= 1'b1;
      seen_one  <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
      push_q    <= 1'b0;
      push_word <= '0;
    end else begin
      push_q <= 1'b0;
      if (start_det || tick) tick_cnt <= '0;
      else                   tick_cnt <= tick_cnt + 16'd1;
      if (tick && state != RX_IDLE) s_cnt <= s_cnt + 4'd1;
      if (tick && s_cnt == 4'(SAMPLE_MID - 1)) s7 <= rx_s;
      if (tick && s_cnt == 4'(SAMPLE_MID))     s8 <= rx_s;
      unique case (state)
        RX_IDLE: if (start_det) begin
          state    <= RX_START;
          div_q    <= baud_div_i;
          pmode_q  <= parity_mode_t'(parity_mode_i);
          two_q    <= stop_bits_i;
          s_cnt    <= '0;
          bit_cnt  <= '0;
          seen_one <= 1'b0;
          perr_q   <= 1'b0;
          ferr_q   <= 1'b0;
          brk_q    <= 1'b0;
        end
        RX_START: begin
          if (mid && maj) state <= RX_IDLE;
          else if (last)  state <= RX_DATA;
        end
        RX_DATA: begin
          if (mid) begin
            data_q   <= {maj, data_q[DATA_BITS-1:1]};
            seen_one <= seen_one | maj;
          end
          if (last) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= par_en ? RX_PARITY : RX_STOP;
            end
          end
        end
        RX_PARITY: begin
          if (mid) begin
            perr_q   <= (^data_q) ^ maj ^ (pmode_q == PAR_ODD);
            seen_one <= seen_one | maj;
          end
          if (last) state <= RX_STOP;
        end
        RX_STOP: begin
          if (mid) begin
            if (bit_cnt == 4'd0) brk_q <= !(seen_one | maj);
            ferr_q <= ferr_q | !maj;
            // Push mid-way through the final stop bit to allow a short gap.
            if (bit_cnt == {3'b000, two_q}) begin
              push_q    <= 1'b1;
              push_word <= {tuser_now, data_q};
              state     <= RX_IDLE;
            end
          end else if (last) begin
            bit_cnt <= 4'd1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ov_q <= 1'b0;
    else       ov_q <= push_q && full && !(mst_axis_tready_i && !empty);
  end

  uart_sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (push_q),
    .wr_data_i (push_word),
    .rd_en_i   (mst_axis_tready_i),
    .rd_data_o (rd_word),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (fifo_level_o)
  );

  assign mst_axis_tdata_o  = rd_word[DATA_BITS-1:0];
  assign mst_axis_tuser_o  = rd_word[W-1:DATA_BITS];
  assign mst_axis_tvalid_o = !empty;
  assign overrun_o         = ov_q;
  assign busy_o            = (state != RX_IDLE);

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries, a power of two and at least 2.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock.
REQ-004 The block SHALL have port rst_i, input, 1 bit, reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port rx_i, input, 1 bit, asynchronous serial line, idle high.
REQ-006 The block SHALL have port baud_div_i, input, 16 bits; one oversample tick occurs every baud_div_i+1 clocks.
REQ-007 The block SHALL have port parity_mode_i, input, 2 bits: 0 none, 1 even, 2 odd, 3 treated as none.
REQ-008 The block SHALL have port stop_bits_i, input, 1 bit: 0 one stop bit, 1 two stop bits.
REQ-009 The block SHALL have port mst_axis_tdata_o, output, DATA_BITS bits, received data.
REQ-010 The block SHALL have port mst_axis_tuser_o, output, 3 bits: {break, parity_err, frame_err} of the presented word.
REQ-011 The block SHALL have port mst_axis_tvalid_o, output, 1 bit; port mst_axis_tready_i, input, 1 bit.
REQ-012 The block SHALL have port overrun_o, output, 1 bit, one-cycle pulse when a frame is dropped.
REQ-013 The block SHALL have port fifo_level_o, output, $clog2(FIFO_DEPTH)+1 bits, occupied entries.
REQ-014 The block SHALL have port busy_o, output, 1 bit, high whenever the FSM is not IDLE.

Function
REQ-015 rx_i SHALL pass through a 2-flop synchroniser before any use.
REQ-016 Tick counter: counts 0..baud_div_i; tick on terminal count; free-running in IDLE; restarted at 0 on start detect; baud_div_i=0 gives a tick every clock.
REQ-017 Oversampling SHALL be 16 ticks per bit; each bit value = majority of samples 7, 8, 9.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE->START on a synchronised high-to-low transition; baud_div_i, parity_mode_i and stop_bits_i latched here and held for the frame.
REQ-020 START: majority=1 at mid-bit -> IDLE (false start, nothing pushed); else -> DATA.
REQ-021 DATA: DATA_BITS bits, LSB first; then -> PARITY if parity enabled, else -> STOP.
REQ-022 PARITY: parity_err=1 if received parity mismatches even/odd of the data bits.
REQ-023 STOP: frame_err=1 if any stop bit samples 0; push occurs at mid-sample of the last stop bit; FSM -> IDLE in the same cycle.
REQ-024 break=1 iff all data bits, the parity bit (if any) and the first stop bit are 0.
REQ-025 After IDLE, a new start requires a fresh falling edge; a line held low SHALL NOT retrigger.
REQ-026 Push to a full FIFO without a same-cycle pop: frame dropped, overrun_o=1 for exactly one cycle, FIFO unchanged.
REQ-027 Push and pop in the same cycle when full SHALL both succeed; level unchanged, no overrun.
REQ-028 mst_axis_tvalid_o = FIFO not empty, with 1-cycle latency from push to tvalid.
REQ-029 tdata/tuser SHALL be stable while tvalid && !tready; pop on tvalid && tready.
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH; words SHALL be delivered in arrival order.

Reset
REQ-031 On rst_i: FSM IDLE, tick counter 0, synchroniser flops 1, FIFO empty.
REQ-032 On rst_i: tvalid_o, tdata_o, tuser_o, overrun_o and busy_o = 0; fifo_level_o = 0.
REQ-033 Reset mid-frame SHALL discard the partial frame; the first frame after release SHALL be received correctly.

Structure
REQ-034 Package uart_pkg SHALL hold parity_mode_t, rx_state_t, OVS=16, SAMPLE_MID=8 and the tuser bit indices.
REQ-035 The FIFO SHALL be sub-module uart_sync_fifo, parametrised by width and depth, providing full, empty and level.

Verification (baud_div_i=3 unless stated: 64 clocks per bit)
REQ-036 8N1, serialise 0xA5 -> one word, tdata=0xA5, tuser=000, tvalid about 9.5 bit times after the start edge.
REQ-037 8E1, 0x01 sent with parity bit 0 -> tdata=0x01, tuser=010; 7O2 with DATA_BITS=7, 0x55 -> tuser=000.
REQ-038 rx_i low for 20 clocks then high -> no push, busy_o returns to 0, fifo_level_o stays 0.
REQ-039 FIFO_DEPTH=4, tready=0, send 0x11..0x55 -> level=4, one overrun_o pulse; drain yields 0x11, 0x22, 0x33, 0x44.
REQ-040 rx_i low for 12 bit times -> tdata=0x00, tuser=101; no second word until rx_i rises and falls again.
REQ-041 rst_i asserted during DATA of frame 0x3C, then frame 0xC3 sent -> outputs zeroed, single word 0xC3 received.
